// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl: two-player quiz round controller with lockout, timeout and saturating scores
//   clk, rst                  clock, synchronous active-high reset
//   start, bank_sel           round start pulse (IDLE/DONE only), bank latched on accepted start
//   exp_ans                   expected one-hot answer for current q_idx/bank
//   joy_left, joy_right       player joystick levels; a press is a 0 -> nonzero transition
//   q_idx, bank               current question address for the external table
//   asking, hit_left/right    ASK indicator, per-question result flags held in RESULT
//   score_left/right          saturating binary scores
//   done, winner              round finished; 01 left, 10 right, 11 tie
module quiz_round_ctrl #(
    parameter int NUM_Q      = 9,
    parameter int ANS_W      = 9,
    parameter int TIMEOUT    = 1000,
    parameter int RESULT_CYC = 50,
    parameter int SC_W       = 4,
    localparam int QW        = NUM_Q > 1 ? $clog2(NUM_Q) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bank_sel,
    input  logic [ANS_W-1:0] exp_ans,
    input  logic [ANS_W-1:0] joy_left,
    input  logic [ANS_W-1:0] joy_right,
    output logic [QW-1:0]    q_idx,
    output logic             bank,
    output logic             asking,
    output logic             hit_left,
    output logic             hit_right,
    output logic [SC_W-1:0]  score_left,
    output logic [SC_W-1:0]  score_right,
    output logic             done,
    output logic [1:0]       winner
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(RESULT_CYC + 1);

    typedef enum logic [1:0] {IDLE, ASK, RESULT, DONE} state_t;

    state_t            state_q;
    logic [ANS_W-1:0]  prev_l_q, prev_r_q;
    logic              lock_l_q, lock_r_q, lock_l_d, lock_r_d;
    logic [TW-1:0]     timer_q;
    logic [RW-1:0]     rcnt_q;
    logic [QW-1:0]     q_idx_q;
    logic              bank_q, asking_q, hit_l_q, hit_r_q, done_q;
    logic [SC_W-1:0]   sc_l_q, sc_r_q, sc_l_d, sc_r_d;
    logic [1:0]        winner_q;
    logic              ev_l, ev_r, good_l, good_r, timeout, res_end, last_q;

    assign q_idx       = q_idx_q;
    assign bank        = bank_q;
    assign asking      = asking_q;
    assign hit_left    = hit_l_q;
    assign hit_right   = hit_r_q;
    assign score_left  = sc_l_q;
    assign score_right = sc_r_q;
    assign done        = done_q;
    assign winner      = winner_q;

    always_comb begin
        ev_l     = joy_left != '0 && prev_l_q == '0;
        ev_r     = joy_right != '0 && prev_r_q == '0;
        // x & (x-1) == 0 with x != 0 means exactly one bit set
        good_l   = ev_l && !lock_l_q && joy_left == exp_ans && (joy_left & (joy_left - ANS_W'(1))) == '0;
        good_r   = ev_r && !lock_r_q && joy_right == exp_ans && (joy_right & (joy_right - ANS_W'(1))) == '0;
        lock_l_d = lock_l_q | (ev_l && !good_l);
        lock_r_d = lock_r_q | (ev_r && !good_r);
        sc_l_d   = (good_l && sc_l_q != '1) ? sc_l_q + SC_W'(1) : sc_l_q;
        sc_r_d   = (good_r && sc_r_q != '1) ? sc_r_q + SC_W'(1) : sc_r_q;
        timeout  = timer_q == TW'(TIMEOUT - 1);
        res_end  = rcnt_q == RW'(RESULT_CYC - 1);
        last_q   = q_idx_q == QW'(NUM_Q - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prev_l_q <= '0;
            prev_r_q <= '0;
            lock_l_q <= 1'b0;
            lock_r_q <= 1'b0;
            timer_q  <= '0;
            rcnt_q   <= '0;
            q_idx_q  <= '0;
            bank_q   <= 1'b0;
            asking_q <= 1'b0;
            hit_l_q  <= 1'b0;
            hit_r_q  <= 1'b0;
            sc_l_q   <= '0;
            sc_r_q   <= '0;
            done_q   <= 1'b0;
            winner_q <= 2'b00;
        end else begin
            prev_l_q <= joy_left;
            prev_r_q <= joy_right;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q  <= ASK;
                        asking_q <= 1'b1;
                        done_q   <= 1'b0;
                        winner_q <= 2'b00;
                        bank_q   <= bank_sel;
                        q_idx_q  <= '0;
                        sc_l_q   <= '0;
                        sc_r_q   <= '0;
                        timer_q  <= '0;
                        lock_l_q <= 1'b0;
                        lock_r_q <= 1'b0;
                    end
                end
                ASK: begin
                    timer_q  <= timer_q + TW'(1);
                    lock_l_q <= lock_l_d;
                    lock_r_q <= lock_r_d;
                    sc_l_q   <= sc_l_d;
                    sc_r_q   <= sc_r_d;
                    hit_l_q  <= good_l;
                    hit_r_q  <= good_r;
                    // a correct press in the timeout cycle is still scored above
                    if (good_l || good_r || (lock_l_d && lock_r_d) || timeout) begin
                        state_q  <= RESULT;
                        asking_q <= 1'b0;
                        rcnt_q   <= '0;
                    end
                end
                RESULT: begin
                    rcnt_q <= rcnt_q + RW'(1);
                    if (res_end) begin
                        hit_l_q  <= 1'b0;
                        hit_r_q  <= 1'b0;
                        lock_l_q <= 1'b0;
                        lock_r_q <= 1'b0;
                        if (last_q) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            winner_q <= sc_l_q > sc_r_q ? 2'b01 : sc_l_q < sc_r_q ? 2'b10 : 2'b11;
                        end else begin
                            state_q  <= ASK;
                            asking_q <= 1'b1;
                            q_idx_q  <= q_idx_q + QW'(1);
                            timer_q  <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_quiz_round_ctrl.sv
// tb_quiz_round_ctrl: scenario and randomized checks of quiz_round_ctrl against a per-question model
module tb_quiz_round_ctrl;
    localparam int NUM_Q = 5, ANS_W = 9, TIMEOUT = 12, RESULT_CYC = 3, SC_W = 2, QW = 3;
    localparam int SMAX = 3;

    logic             clk = 1'b0, rst, start, bank_sel;
    logic [ANS_W-1:0] exp_ans, joy_left, joy_right;
    logic [QW-1:0]    q_idx;
    logic             bank, asking, hit_left, hit_right, done;
    logic [SC_W-1:0]  score_left, score_right;
    logic [1:0]       winner;

    logic [ANS_W-1:0] tab [2][NUM_Q];
    logic [ANS_W-1:0] pl [TIMEOUT];
    logic [ANS_W-1:0] pr [TIMEOUT];
    logic [ANS_W-1:0] prevl, prevr, rest_l, rest_r;
    int               ml, mr, mq;
    logic             mbank;
    int               n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    assign exp_ans = tab[bank][q_idx];

    quiz_round_ctrl #(.NUM_Q(NUM_Q), .ANS_W(ANS_W), .TIMEOUT(TIMEOUT), .RESULT_CYC(RESULT_CYC), .SC_W(SC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .bank_sel(bank_sel), .exp_ans(exp_ans),
        .joy_left(joy_left), .joy_right(joy_right), .q_idx(q_idx), .bank(bank), .asking(asking),
        .hit_left(hit_left), .hit_right(hit_right), .score_left(score_left), .score_right(score_right),
        .done(done), .winner(winner)
    );

    task tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return v > SMAX ? SMAX : v;
    endfunction

    function automatic logic [ANS_W-1:0] rand_oh();
        return ANS_W'(1) << $urandom_range(1, ANS_W - 1);
    endfunction

    task clear_plan;
        for (int k = 0; k < TIMEOUT; k++) begin
            pl[k] = '0;
            pr[k] = '0;
        end
    endtask

    task automatic do_start(input logic b, input string tag);
        start = 1'b1;
        bank_sel = b;
        joy_left = '0;
        joy_right = '0;
        tick;
        start = 1'b0;
        bank_sel = ~b;
        prevl = '0; prevr = '0; rest_l = '0; rest_r = '0;
        ml = 0; mr = 0; mq = 0; mbank = b;
        n_chk++;
        if (asking !== 1'b1 || bank !== b || q_idx !== '0 || score_left !== '0 || score_right !== '0 ||
            done !== 1'b0 || winner !== 2'b00) begin
            n_fail++;
            $display("FAIL %s start: asking=%b bank=%b q=%0d sl=%0d sr=%0d done=%b win=%b, want asking=1 bank=%b q=0 scores 0 done=0 win=00",
                     tag, asking, bank, q_idx, score_left, score_right, done, winner, b);
        end
    endtask

    // Plays the current question from the schedules pl/pr; model follows the rules on press events,
    // lockout, timeout and scoring one cycle at a time, then checks RESULT hold and the advance.
    task automatic play_question(input string tag);
        logic [ANS_W-1:0] e;
        logic lkl, lkr, gl, gr, evl, evr, fin;
        logic [1:0] w;
        e = tab[mbank][mq];
        lkl = 0; lkr = 0; gl = 0; gr = 0; fin = 0;
        for (int k = 0; k < TIMEOUT && !fin; k++) begin
            joy_left = pl[k];
            joy_right = pr[k];
            evl = pl[k] != '0 && prevl == '0;
            evr = pr[k] != '0 && prevr == '0;
            gl = evl && !lkl && pl[k] == e && $countones(pl[k]) == 1;
            gr = evr && !lkr && pr[k] == e && $countones(pr[k]) == 1;
            lkl = lkl || (evl && !gl);
            lkr = lkr || (evr && !gr);
            prevl = pl[k];
            prevr = pr[k];
            if (gl) ml = sat(ml + 1);
            if (gr) mr = sat(mr + 1);
            fin = gl || gr || (lkl && lkr) || k == TIMEOUT - 1;
            tick;
            n_chk++;
            if (asking !== !fin) begin
                n_fail++;
                $display("FAIL %s q%0d cycle %0d asking: got %b want %b", tag, mq, k, asking, !fin);
            end
        end
        n_chk++;
        if ({hit_left, hit_right} !== {gl, gr} || score_left !== SC_W'(ml) || score_right !== SC_W'(mr)) begin
            n_fail++;
            $display("FAIL %s q%0d result: hits=%b%b sl=%0d sr=%0d, want hits=%b%b sl=%0d sr=%0d",
                     tag, mq, hit_left, hit_right, score_left, score_right, gl, gr, ml, mr);
        end
        joy_left = rest_l;
        joy_right = rest_r;
        prevl = rest_l;
        prevr = rest_r;
        for (int i = 1; i < RESULT_CYC; i++) begin
            tick;
            n_chk++;
            if ({asking, hit_left, hit_right} !== {1'b0, gl, gr}) begin
                n_fail++;
                $display("FAIL %s q%0d hold %0d: asking/hits=%b%b%b want 0%b%b", tag, mq, i, asking, hit_left, hit_right, gl, gr);
            end
        end
        tick;
        if (mq == NUM_Q - 1) begin
            w = ml > mr ? 2'b01 : ml < mr ? 2'b10 : 2'b11;
            n_chk++;
            if ({done, asking, hit_left, hit_right} !== 4'b1000 || winner !== w) begin
                n_fail++;
                $display("FAIL %s done: done/asking/hits=%b%b%b%b win=%b, want 1000 win=%b",
                         tag, done, asking, hit_left, hit_right, winner, w);
            end
        end else begin
            mq++;
            n_chk++;
            if ({asking, done, hit_left, hit_right} !== 4'b1000 || q_idx !== QW'(mq) || bank !== mbank) begin
                n_fail++;
                $display("FAIL %s advance: asking/done/hits=%b%b%b%b q=%0d bank=%b, want 1000 q=%0d bank=%b",
                         tag, asking, done, hit_left, hit_right, q_idx, bank, mq, mbank);
            end
        end
    endtask

    task test_reset;
        rst = 1'b1; start = 1'b0; bank_sel = 1'b0; joy_left = '0; joy_right = '0;
        repeat (3) tick;
        n_chk++;
        if ({asking, done, hit_left, hit_right, bank} !== 5'b0 || q_idx !== '0 || score_left !== '0 ||
            score_right !== '0 || winner !== 2'b00) begin
            n_fail++;
            $display("FAIL reset: asking=%b done=%b hits=%b%b bank=%b q=%0d sl=%0d sr=%0d win=%b, want all 0",
                     asking, done, hit_left, hit_right, bank, q_idx, score_left, score_right, winner);
        end
        rst = 1'b0;
        joy_left = tab[0][0];
        tick;
        joy_left = '0;
        tick;
        n_chk++;
        if (asking !== 1'b0 || score_left !== '0) begin
            n_fail++;
            $display("FAIL idle_hold: asking=%b sl=%0d, want asking=0 sl=0", asking, score_left);
        end
    endtask

    task test_single_correct;
        do_start(1'b0, "single");
        clear_plan;
        pl[2] = 9'b000001000;
        play_question("single");
    endtask

    task test_lockout;
        start = 1'b1;
        bank_sel = 1'b1;
        clear_plan;
        pl[1] = 9'b000000001;
        pl[3] = tab[0][1];
        pr[5] = tab[0][1];
        play_question("lockout");
        start = 1'b0;
    endtask

    task test_both;
        clear_plan;
        pl[2] = tab[0][2];
        pr[2] = tab[0][2];
        play_question("both");
    endtask

    task test_timeout_held;
        clear_plan;
        for (int k = 2; k < TIMEOUT; k++) pl[k] = tab[0][3];
        rest_l = tab[0][3];
        play_question("held_q3");
        for (int k = 0; k < TIMEOUT; k++) pl[k] = tab[0][3];
        play_question("held_timeout");
        rest_l = '0;
        joy_left = '0;
        tick;
        tick;
        n_chk++;
        if (done !== 1'b1 || score_left !== SC_W'(ml) || score_right !== SC_W'(mr)) begin
            n_fail++;
            $display("FAIL done_hold: done=%b sl=%0d sr=%0d, want done=1 sl=%0d sr=%0d", done, score_left, score_right, ml, mr);
        end
    endtask

    task test_winner;
        do_start(1'b0, "winner");
        for (int q = 0; q < NUM_Q; q++) begin
            clear_plan;
            if (q % 2 == 0) pl[1 + q] = tab[0][q];
            else pr[1 + q] = tab[0][q];
            play_question("winner");
        end
    endtask

    task test_saturate;
        do_start(1'b0, "saturate");
        for (int q = 0; q < NUM_Q; q++) begin
            clear_plan;
            pl[1] = tab[0][q];
            play_question("saturate");
        end
        n_chk++;
        if (score_left !== 2'd3 || winner !== 2'b01) begin
            n_fail++;
            $display("FAIL saturate: sl=%0d win=%b, want sl=3 win=01", score_left, winner);
        end
    endtask

    task test_reset_mid;
        do_start(1'b1, "restart");
        for (int q = 0; q < 3; q++) begin
            clear_plan;
            pl[1] = tab[1][q];
            play_question("reset_mid");
        end
        n_chk++;
        if (score_left !== 2'd3 || asking !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: sl=%0d asking=%b, want sl=3 asking=1", score_left, asking);
        end
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        ml = 0; mr = 0; mq = 0; mbank = 1'b0; prevl = '0; prevr = '0;
        n_chk++;
        if ({asking, done, hit_left, hit_right, bank} !== 5'b0 || q_idx !== '0 || score_left !== '0 ||
            score_right !== '0 || winner !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid: asking=%b done=%b hits=%b%b bank=%b q=%0d sl=%0d sr=%0d win=%b, want all 0",
                     asking, done, hit_left, hit_right, bank, q_idx, score_left, score_right, winner);
        end
    endtask

    task test_random;
        int s;
        for (int r = 0; r < 8; r++) begin
            do_start(1'($urandom_range(0, 1)), "random");
            for (int q = 0; q < NUM_Q; q++) begin
                for (int k = 0; k < TIMEOUT; k++) begin
                    s = $urandom_range(0, 19);
                    pl[k] = s < 11 ? '0 : s < 14 ? tab[mbank][q] : s < 17 ? rand_oh() : ANS_W'($urandom);
                    s = $urandom_range(0, 19);
                    pr[k] = s < 11 ? '0 : s < 14 ? tab[mbank][q] : s < 17 ? rand_oh() : ANS_W'($urandom);
                end
                play_question("random");
            end
        end
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int q = 0; q < NUM_Q; q++) tab[b][q] = rand_oh();
        tab[0][0] = 9'b000001000;
        prevl = '0; prevr = '0; rest_l = '0; rest_r = '0;
        test_reset;
        test_single_correct;
        test_lockout;
        test_both;
        test_timeout_held;
        test_winner;
        test_saturate;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
